// File: rtl/routing_error_correction_pkg.sv
// rtl/routing_error_correction_pkg.sv - shared Hamming(7,4) constants, types and encoder
//
// Purpose: codeword bit positions, codeword/destination types, display count and
//          the combinational Hamming(7,4) encoder used by the routing pipeline.
// Ports:   none (package).
package routing_error_correction_pkg;

  // Codeword positions, numbered 1..7 as in the classic Hamming layout.
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int D1 = 3;
  localparam int P4 = 4;
  localparam int D2 = 5;
  localparam int D3 = 6;
  localparam int D4 = 7;

  localparam int DISPLAY_COUNT = 4;

  // Indexed [7:1] so that a bit index is the Hamming position itself.
  typedef logic [7:1] codeword_t;
  typedef logic [1:0] dest_t;

  // data[3] is d1 (payload MSB), data[0] is d4.
  function automatic codeword_t hamming74_encode(input logic [3:0] data);
    codeword_t cw;
    cw     = '0;
    cw[P1] = data[3] ^ data[2] ^ data[0];
    cw[P2] = data[3] ^ data[1] ^ data[0];
    cw[D1] = data[3];
    cw[P4] = data[2] ^ data[1] ^ data[0];
    cw[D2] = data[2];
    cw[D3] = data[1];
    cw[D4] = data[0];
    return cw;
  endfunction

endpackage

// File: rtl/routing_error_correction_decoder.sv
// rtl/routing_error_correction_decoder.sv - combinational Hamming(7,4) single-error corrector
//
// Purpose: computes the syndrome of a received codeword, flips the addressed
//          position when the syndrome is nonzero and extracts the 4 data bits.
// Ports:   cw       in  7  received codeword, bit index = Hamming position
//          data     out 4  corrected data {pos3,pos5,pos6,pos7}, MSB first
//          syndrome out 3  {s4,s2,s1}; nonzero value names the bad position
module hamming74_decoder
  import routing_error_correction_pkg::*;
(
  input  codeword_t   cw,
  output logic [3:0]  data,
  output logic [2:0]  syndrome
);

  codeword_t fix_mask;
  codeword_t fixed_cw;

  always_comb begin
    syndrome[0] = cw[P1] ^ cw[D1] ^ cw[D2] ^ cw[D4];
    syndrome[1] = cw[P2] ^ cw[D1] ^ cw[D3] ^ cw[D4];
    syndrome[2] = cw[P4] ^ cw[D2] ^ cw[D3] ^ cw[D4];
  end

  // Bit index 1 is the LSB of codeword_t, so shifting by (s-1) lands on position s.
  always_comb begin
    fix_mask = '0;
    if (syndrome != 3'd0) begin
      fix_mask = codeword_t'(7'b1 << (syndrome - 3'd1));
    end
    fixed_cw = cw ^ fix_mask;
  end

  assign data = {fixed_cw[D1], fixed_cw[D2], fixed_cw[D3], fixed_cw[D4]};

endmodule

// File: rtl/routing_error_correction.sv
// rtl/routing_error_correction.sv - three-stage Hamming-protected routing pipeline to four displays
//
// Purpose: registers {dest,payload}, encodes the payload into a Hamming(7,4)
//          codeword with optional deterministic single-bit corruption, then
//          corrects it and writes the data into the addressed display register.
// Ports:   clk      in  1  rising-edge clock
//          rst      in  1  asynchronous active-low reset
//          d_in     in  6  [0:1] destination (d_in[0] MSB), [2:5] payload (d_in[2] MSB)
//          d_disp0  out 4  display for destination 00 (bit 1 = MSB)
//          d_disp1  out 4  display for destination 01
//          d_disp2  out 4  display for destination 10
//          d_disp3  out 4  display for destination 11
// Param:   INJECT_EN 1 = invert codeword position k when the injection counter is k (k=1..7)
module routing_error_correction
  import routing_error_correction_pkg::*;
#(
  parameter bit INJECT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [0:5] d_in,
  output logic [1:4] d_disp0,
  output logic [1:4] d_disp1,
  output logic [1:4] d_disp2,
  output logic [1:4] d_disp3
);

  // Stage 1: raw input register.
  dest_t       in_dest;
  logic [3:0]  in_payload;

  // Stage 2: (possibly corrupted) codeword register; destination travels uncoded.
  codeword_t   cw_reg;
  dest_t       cw_dest;

  logic [2:0]  inj_cnt;
  codeword_t   inj_mask;
  codeword_t   tx_cw;

  logic [3:0]  dec_data;
  logic [2:0]  syndrome;

  logic [3:0]  disp [DISPLAY_COUNT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_dest    <= '0;
      in_payload <= '0;
    end else begin
      in_dest    <= d_in[0:1];
      in_payload <= d_in[2:5];
    end
  end

  // Free-running phase counter; its value selects which position gets flipped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_cnt <= 3'd0;
    end else begin
      inj_cnt <= inj_cnt + 3'd1;
    end
  end

  always_comb begin
    inj_mask = '0;
    if (INJECT_EN && (inj_cnt != 3'd0)) begin
      inj_mask = codeword_t'(7'b1 << (inj_cnt - 3'd1));
    end
    tx_cw = hamming74_encode(in_payload) ^ inj_mask;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cw_reg  <= '0;
      cw_dest <= '0;
    end else begin
      cw_reg  <= tx_cw;
      cw_dest <= in_dest;
    end
  end

  hamming74_decoder u_dec (
    .cw       (cw_reg),
    .data     (dec_data),
    .syndrome (syndrome)
  );

  // Stage 3: routing demux; only the addressed display is updated.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DISPLAY_COUNT; i++) begin
        disp[i] <= '0;
      end
    end else begin
      disp[cw_dest] <= dec_data;
    end
  end

  assign d_disp0 = disp[0];
  assign d_disp1 = disp[1];
  assign d_disp2 = disp[2];
  assign d_disp3 = disp[3];

endmodule

// File: tb/tb_routing_error_correction.sv
// tb/tb_routing_error_correction.sv - scoreboard bench for the routing error correction pipeline
module tb_routing_error_correction;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [0:5] d_in = '0;

  logic [1:4] a0, a1, a2, a3;
  logic [1:4] b0, b1, b2, b3;

  always #5 clk = ~clk;

  routing_error_correction #(.INJECT_EN(1'b1)) dut_inj (
    .clk(clk), .rst(rst), .d_in(d_in),
    .d_disp0(a0), .d_disp1(a1), .d_disp2(a2), .d_disp3(a3)
  );

  routing_error_correction #(.INJECT_EN(1'b0)) dut_clean (
    .clk(clk), .rst(rst), .d_in(d_in),
    .d_disp0(b0), .d_disp1(b1), .d_disp2(b2), .d_disp3(b3)
  );

  // Expected display write: due = edge number (since reset release) after which
  // the write is visible; syn = syndrome the corrupting DUT shows one edge earlier.
  typedef struct {
    int         due;
    logic [1:0] dest;
    logic [3:0] data;
    logic [2:0] syn;
  } exp_t;

  exp_t       q[$];
  logic [3:0] model [4];
  int         edge_count;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) edge_count <= 0;
    else      edge_count <= edge_count + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int disp_a(input int i);
    case (i)
      0: return int'(a0);
      1: return int'(a1);
      2: return int'(a2);
      default: return int'(a3);
    endcase
  endfunction

  function automatic int disp_b(input int i);
    case (i)
      0: return int'(b0);
      1: return int'(b1);
      2: return int'(b2);
      default: return int'(b3);
    endcase
  endfunction

  // Monitor: the only process that compares.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (!rst) begin
        for (int i = 0; i < 4; i++) begin
          chk($sformatf("reset_inj_disp%0d", i), disp_a(i), 0);
          chk($sformatf("reset_clean_disp%0d", i), disp_b(i), 0);
        end
        q.delete();
        for (int i = 0; i < 4; i++) model[i] = 4'd0;
        // Reset contents of the pipeline flush through as writes of 0 to disp0.
        e.dest = 2'd0; e.data = 4'd0; e.syn = 3'd0;
        e.due = 1; q.push_back(e);
        e.due = 2; q.push_back(e);
      end else begin
        if (q.size() > 0 && q[0].due == edge_count) begin
          e = q.pop_front();
          model[e.dest] = e.data;
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("inj_disp%0d", i), disp_a(i), int'(model[i]));
            chk($sformatf("clean_disp%0d", i), disp_b(i), int'(model[i]));
          end
        end
        if (q.size() > 0 && q[0].due == edge_count + 1) begin
          chk("inj_syndrome", int'(dut_inj.u_dec.syndrome), int'(q[0].syn));
          chk("clean_syndrome", int'(dut_clean.u_dec.syndrome), 0);
        end
      end
    end
  end

  // Drive one sample for the next rising edge and record what it must produce.
  task automatic drive(input logic [5:0] v);
    exp_t e;
    @(negedge clk);
    d_in = v;
    if (rst) begin
      e.due  = edge_count + 3;
      e.dest = v[5:4];
      e.data = v[3:0];
      e.syn  = 3'((edge_count + 1) % 8);
      q.push_back(e);
    end
  endtask

  // Assert reset between edges, hold for n edges, release between edges.
  task automatic do_reset(input int n);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (n) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    do_reset(2);
    repeat (20) drive(6'b001011);

    do_reset(1);
    repeat (20) drive(6'b011011);

    do_reset(1);
    repeat (20) drive(6'b101011);

    do_reset(1);
    repeat (20) drive(6'b111011);

    repeat (6) drive(6'b000101);
    repeat (6) drive(6'b110010);

    for (int v = 0; v < 64; v++) begin
      for (int p = 0; p < 8; p++) drive(6'(v));
    end

    repeat (13) drive(6'($urandom_range(0, 63)));
    do_reset(1);
    repeat (200) drive(6'($urandom_range(0, 63)));

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
